// File: rtl/fetch_seq_if.sv
// Bundles the redirect, instruction-memory and decode-side handshake signals of fetch_seq.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_seq_if;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        exc_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redir_valid, redir_pc, exc_valid, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redir_valid, redir_pc, exc_valid, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_seq.sv
// Single-outstanding instruction fetch sequencer with a one-entry instruction buffer.
// Redirects and exceptions that arrive while a fetch is in flight mark its data for discard.
module fetch_seq #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          rstn,
  fetch_seq_if.master   bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        discard_q, discard_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic        req;
  logic [31:0] target;

  // Exception wins over a same-cycle redirect; redirect targets are forced word-aligned.
  assign req    = bus.exc_valid | bus.redir_valid;
  assign target = bus.exc_valid ? EXC_VECTOR : {bus.redir_pc[31:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    discard_d = discard_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    unique case (state_q)
      StIdle: begin
        state_d = StIssue;
        if (req) pc_d = target;
      end
      StIssue: begin
        if (bus.imem_gnt) begin
          state_d = StWait;
          if (req) begin
            discard_d = 1'b1;
            tgt_d     = target;
          end
        end else if (req) begin
          pc_d = target;
        end
      end
      StWait: begin
        if (bus.imem_rvalid) begin
          if (req) begin
            // Returning word belongs to the old path; restart at the new target directly.
            pc_d      = target;
            discard_d = 1'b0;
            state_d   = StIssue;
          end else if (discard_q) begin
            pc_d      = tgt_q;
            discard_d = 1'b0;
            state_d   = StIssue;
          end else begin
            inst_d    = bus.imem_rdata;
            inst_pc_d = pc_q;
            state_d   = StOut;
          end
        end else if (req) begin
          discard_d = 1'b1;
          tgt_d     = target;
        end
      end
      StOut: begin
        if (req) begin
          pc_d    = target;
          state_d = StIssue;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      tgt_q     <= 32'h0;
      discard_q <= 1'b0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      discard_q <= discard_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign bus.imem_req   = (state_q == StIssue);
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (state_q == StOut);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: each task drives one scenario and checks outputs 1ns after
// the rising edge against hand-computed values.
module tb_fetch_seq;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  fetch_seq_if bus ();

  fetch_seq #(
    .RESET_PC  (32'h0000_3000),
    .EXC_VECTOR(32'h0000_4180)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 32'h0;
    bus.exc_valid   = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.inst_ready  = 1'b0;
  endtask

  task automatic test_reset();
    logic [97:0] act;
    rstn = 1'b0;
    idle_inputs();
    step();
    step();
    act = {bus.imem_req, bus.inst_valid, bus.imem_addr, bus.inst, bus.inst_pc};
    checks++;
    if (act !== {1'b0, 1'b0, 32'h0000_3000, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", act,
               {1'b0, 1'b0, 32'h0000_3000, 32'h0, 32'h0});
    end
    rstn = 1'b1;
    step();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0000_3000}) begin
      errors++;
      $display("FAIL reset_release_issue: got %h expected %h", {bus.imem_req, bus.imem_addr},
               {1'b1, 32'h0000_3000});
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    logic [31:0] word;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'h0000_3000 + 32'(4 * i);
      word     = 32'h1000_0013 + 32'(i);
      checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp_addr}) begin
        errors++;
        $display("FAIL seq_addr[%0d]: got %h expected %h", i, {bus.imem_req, bus.imem_addr},
                 {1'b1, exp_addr});
      end
      bus.imem_gnt = 1'b1;
      step();
      bus.imem_gnt = 1'b0;
      checks++;
      if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin
        errors++;
        $display("FAIL seq_wait[%0d]: got %b expected 00", i, {bus.imem_req, bus.inst_valid});
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word;
      step();
      bus.imem_rvalid = 1'b0;
      checks++;
      if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, word, exp_addr}) begin
        errors++;
        $display("FAIL seq_out[%0d]: got %h expected %h", i,
                 {bus.inst_valid, bus.inst, bus.inst_pc}, {1'b1, word, exp_addr});
      end
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;
    end
  endtask

  task automatic test_redirect_wait();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0000_300C}) begin
      errors++;
      $display("FAIL rw_start: got %h expected %h", {bus.imem_req, bus.imem_addr},
               {1'b1, 32'h0000_300C});
    end
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_3103;
    step();
    bus.redir_valid = 1'b0;
    checks++;
    if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rw_still_wait: got %b expected 00", {bus.imem_req, bus.inst_valid});
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    checks++;
    if ({bus.imem_req, bus.inst_valid, bus.imem_addr} !== {2'b10, 32'h0000_3100}) begin
      errors++;
      $display("FAIL rw_dropped: got %h expected %h",
               {bus.imem_req, bus.inst_valid, bus.imem_addr}, {2'b10, 32'h0000_3100});
    end
    step();
    checks++;
    if ({bus.inst_valid, bus.imem_addr} !== {1'b0, 32'h0000_3100}) begin
      errors++;
      $display("FAIL rw_hold: got %h expected %h", {bus.inst_valid, bus.imem_addr},
               {1'b0, 32'h0000_3100});
    end
  endtask

  task automatic test_exc_priority();
    bus.exc_valid   = 1'b1;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_5000;
    step();
    bus.exc_valid   = 1'b0;
    bus.redir_valid = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0000_4180}) begin
      errors++;
      $display("FAIL exc_priority: got %h expected %h", {bus.imem_req, bus.imem_addr},
               {1'b1, 32'h0000_4180});
    end
  endtask

  task automatic test_stall_redirect();
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hA5A5_0001;
    step();
    bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 32'hA5A5_0001, 32'h0000_4180}) begin
        errors++;
        $display("FAIL stall_stable[%0d]: got %h expected %h", i,
                 {bus.inst_valid, bus.inst, bus.inst_pc}, {1'b1, 32'hA5A5_0001, 32'h0000_4180});
      end
      step();
    end
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_3200;
    bus.inst_ready  = 1'b1;
    step();
    bus.redir_valid = 1'b0;
    bus.inst_ready  = 1'b0;
    checks++;
    if ({bus.imem_req, bus.inst_valid, bus.imem_addr} !== {2'b10, 32'h0000_3200}) begin
      errors++;
      $display("FAIL stall_redir_accept: got %h expected %h",
               {bus.imem_req, bus.inst_valid, bus.imem_addr}, {2'b10, 32'h0000_3200});
    end
    // Redirect while decode is stalled: buffer is flushed without acceptance.
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hA5A5_0002;
    step();
    bus.imem_rvalid = 1'b0;
    checks++;
    if ({bus.inst_valid, bus.inst_pc} !== {1'b1, 32'h0000_3200}) begin
      errors++;
      $display("FAIL out_3200: got %h expected %h", {bus.inst_valid, bus.inst_pc},
               {1'b1, 32'h0000_3200});
    end
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_3300;
    step();
    bus.redir_valid = 1'b0;
    checks++;
    if ({bus.imem_req, bus.inst_valid, bus.imem_addr} !== {2'b10, 32'h0000_3300}) begin
      errors++;
      $display("FAIL stall_redir_flush: got %h expected %h",
               {bus.imem_req, bus.inst_valid, bus.imem_addr}, {2'b10, 32'h0000_3300});
    end
  endtask

  task automatic test_issue_gnt_redirect();
    bus.imem_gnt    = 1'b1;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_0600;
    step();
    bus.imem_gnt    = 1'b0;
    bus.redir_valid = 1'b0;
    checks++;
    if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin
      errors++;
      $display("FAIL igr_wait: got %b expected 00", {bus.imem_req, bus.inst_valid});
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0BAD_0BAD;
    step();
    bus.imem_rvalid = 1'b0;
    checks++;
    if ({bus.imem_req, bus.inst_valid, bus.imem_addr} !== {2'b10, 32'h0000_0600}) begin
      errors++;
      $display("FAIL igr_dropped: got %h expected %h",
               {bus.imem_req, bus.inst_valid, bus.imem_addr}, {2'b10, 32'h0000_0600});
    end
  endtask

  task automatic test_back_to_back();
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h0000_0100;
    step();
    bus.redir_pc = 32'h0000_0205;
    step();
    bus.redir_valid = 1'b0;
    step();
    checks++;
    if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_wait: got %b expected 00", {bus.imem_req, bus.inst_valid});
    end
    bus.imem_rvalid = 1'b1;
    step();
    bus.imem_rvalid = 1'b0;
    checks++;
    if ({bus.imem_req, bus.inst_valid, bus.imem_addr} !== {2'b10, 32'h0000_0204}) begin
      errors++;
      $display("FAIL b2b_later_wins: got %h expected %h",
               {bus.imem_req, bus.inst_valid, bus.imem_addr}, {2'b10, 32'h0000_0204});
    end
  endtask

  task automatic test_wrap();
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'hFFFF_FFFC;
    step();
    bus.redir_valid = 1'b0;
    checks++;
    if (bus.imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top: got %h expected %h", bus.imem_addr, 32'hFFFF_FFFC);
    end
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0073;
    step();
    bus.imem_rvalid = 1'b0;
    checks++;
    if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 32'h0000_0073, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_out: got %h expected %h", {bus.inst_valid, bus.inst, bus.inst_pc},
               {1'b1, 32'h0000_0073, 32'hFFFF_FFFC});
    end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    checks++;
    if ({bus.imem_req, bus.inst_valid, bus.imem_addr} !== {2'b10, 32'h0000_0000}) begin
      errors++;
      $display("FAIL wrap_zero: got %h expected %h",
               {bus.imem_req, bus.inst_valid, bus.imem_addr}, {2'b10, 32'h0000_0000});
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [97:0] act;
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    act = {bus.imem_req, bus.inst_valid, bus.imem_addr, bus.inst, bus.inst_pc};
    checks++;
    if (act !== {2'b00, 32'h0000_3000, 32'h0000_0073, 32'hFFFF_FFFC} &&
        act !== {2'b00, 32'h0000_3000, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL rst_async: got %h expected %h", act, {2'b00, 32'h0000_3000, 32'h0, 32'h0});
    end
    checks++;
    if (act !== {2'b00, 32'h0000_3000, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL rst_async_clear: got %h expected %h", act,
               {2'b00, 32'h0000_3000, 32'h0, 32'h0});
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0001;
    step();
    step();
    checks++;
    if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rst_rvalid_ignored: got %b expected 00", {bus.imem_req, bus.inst_valid});
    end
    bus.imem_rvalid = 1'b0;
    rstn            = 1'b1;
    step();
    checks++;
    if ({bus.imem_req, bus.inst_valid, bus.imem_addr} !== {2'b10, 32'h0000_3000}) begin
      errors++;
      $display("FAIL rst_first_req: got %h expected %h",
               {bus.imem_req, bus.inst_valid, bus.imem_addr}, {2'b10, 32'h0000_3000});
    end
    bus.imem_rvalid = 1'b1;
    step();
    bus.imem_rvalid = 1'b0;
    checks++;
    if ({bus.imem_req, bus.inst_valid, bus.imem_addr} !== {2'b10, 32'h0000_3000}) begin
      errors++;
      $display("FAIL rst_stale_rvalid: got %h expected %h",
               {bus.imem_req, bus.inst_valid, bus.imem_addr}, {2'b10, 32'h0000_3000});
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_wait();
    test_exc_priority();
    test_stall_redirect();
    test_issue_gnt_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL provide parameter EXC_VECTOR, default 32'h0000_4180, meaning the fetch target on an exception.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port redir_valid  input  1  one-cycle pulse: a branch, jump or jr/jalr target is resolved.
REQ-006 SHALL have port redir_pc  input  32  redirect target from the next-PC unit; bits [1:0] are ignored and treated as 2'b00.
REQ-007 SHALL have port exc_valid  input  1  one-cycle pulse: an exception is raised; target is EXC_VECTOR.
REQ-008 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-009 SHALL have port imem_addr  output  32  fetch address; equals the current pc register.
REQ-010 SHALL have port imem_gnt  input  1  memory accepts the request in this cycle.
REQ-011 SHALL have port imem_rvalid  input  1  read data valid; occurs at least 1 cycle after the grant.
REQ-012 SHALL have port imem_rdata  input  32  instruction word.
REQ-013 SHALL have port inst_valid  output  1  instruction buffer holds a valid instruction.
REQ-014 SHALL have port inst  output  32  buffered instruction.
REQ-015 SHALL have port inst_pc  output  32  address of the buffered instruction.
REQ-016 SHALL have port inst_ready  input  1  decode accepts the instruction; the handshake completes when inst_valid and inst_ready are both high.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT and OUT, with at most one fetch outstanding.
REQ-018 SHALL leave IDLE unconditionally: IDLE -> ISSUE in the first cycle after reset is released.
REQ-019 SHALL drive imem_req=1 in ISSUE only; ISSUE -> WAIT on imem_gnt, otherwise stay in ISSUE.
REQ-020 SHALL, in WAIT on imem_rvalid with the discard flag clear, load inst<=imem_rdata and inst_pc<=pc, and go to OUT.
REQ-021 SHALL, in WAIT on imem_rvalid with the discard flag set, drop the data, clear the flag, load pc from the pending target, and go to ISSUE.
REQ-022 SHALL hold inst_valid=1 in OUT only, with inst and inst_pc stable until the handshake completes.
REQ-023 SHALL, on a handshake with no redirect or exception, update pc<=pc+4 modulo 2^32 (32'hFFFF_FFFC -> 0) and go to ISSUE.
REQ-024 SHALL give exc_valid priority over redir_valid when both are high in the same cycle.
REQ-025 SHALL let the later of two requests in different cycles overwrite the pending target.
REQ-026 SHALL, on a redirect or exception in ISSUE without imem_gnt, load pc<=target next cycle and keep imem_req=1 with the new address.
REQ-027 SHALL, on a redirect or exception in ISSUE with imem_gnt in the same cycle, set the discard flag, store the target and go to WAIT.
REQ-028 SHALL, on a redirect or exception in WAIT, set the discard flag and store the target; a same-cycle imem_rvalid is also discarded.
REQ-029 SHALL, on a redirect or exception in OUT without inst_ready, clear inst_valid next cycle, load pc<=target and go to ISSUE.
REQ-030 SHALL, on a redirect or exception in OUT with inst_ready, count the instruction as accepted and then load pc<=target (not pc+4) and go to ISSUE.
REQ-031 SHALL ignore a redirect or exception in IDLE except to load pc<=target.
REQ-032 SHALL produce a fetch latency from grant to inst_valid of (rvalid delay + 1) cycles, with no combinational path from imem_rdata to inst.

Reset
REQ-033 SHALL, while rstn=0, force state=IDLE, pc=RESET_PC, discard flag=0, imem_req=0, inst_valid=0, inst=0 and inst_pc=0; imem_addr therefore equals RESET_PC.
REQ-034 SHALL, on a reset asserted mid-fetch, abandon the outstanding fetch and ignore any later imem_rvalid until a new grant.

Verification
REQ-035 SHALL cover: reset release, gnt on first request, rvalid 1 cycle later, inst_ready=1 -> addresses 0x3000, 0x3004, 0x3008 fetched in order, with inst_pc matching.
REQ-036 SHALL cover: redir_valid with redir_pc=0x3103 during WAIT -> the in-flight word is dropped (inst_valid stays 0) and the next imem_addr is 0x3100.
REQ-037 SHALL cover: exc_valid and redir_valid (0x5000) in the same cycle during ISSUE without gnt -> imem_addr becomes 0x4180 the next cycle.
REQ-038 SHALL cover: OUT with inst_ready=0 for 5 cycles -> inst and inst_pc stable; then redirect to 0x3200 with inst_ready=1 -> instruction accepted and the next fetch is 0x3200.
REQ-039 SHALL cover: pc=0xFFFF_FFFC accepted -> next imem_addr is 0x0000_0000.
REQ-040 SHALL cover: rstn asserted in WAIT, then rvalid during reset -> inst_valid stays 0 and the first request after release targets 0x3000.
